decode: RTL and testbench
=========================

# decode

Decode/write-back stage of the five-stage Y86-64 pipeline, directly downstream of fetch. Consumes the D pipeline register (D_stat..D_valP), owns the 15×64-bit program register file (written from the W stage), selects source/destination register IDs, resolves operands through the forwarding network, and loads the E pipeline register under bubble control from the hazard unit. Also exports d_srcA/d_srcB combinationally so the hazard unit can detect load/use.

## Interface
- NREG, 15: architectural registers, IDs 0x0–0xE; 0xF = RNONE.
- RSP, 4'h4: stack pointer ID.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- D_stat  in  3  fetch status (AOK=1, HLT=2, ADR=3, INS=4).
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decoded fields.
- D_valC, D_valP  in  64 each  constant, next PC.
- e_dstE, e_valE  in  4/64  execute-stage ALU result (pre-register).
- M_dstE, M_valE, M_dstM, m_valM  in  4/64/4/64  memory-stage results.
- W_dstE, W_valE, W_dstM, W_valM  in  4/64/4/64  write-back results; also register-file write ports.
- E_bubble  in  1  load a nop into E this edge.
- d_srcA, d_srcB  out  4 each  combinational source IDs.
- E_stat  out  3; E_icode, E_ifun  out  4 each; E_valC, E_valA, E_valB  out  64 each; E_dstE, E_dstM, E_srcA, E_srcB  out  4 each: E pipeline register.

## Operation
- srcA: icode 2,4,6,A → D_rA; 9,B → RSP; else 0xF.
- srcB: icode 4,5,6 → D_rB; 8,9,A,B → RSP; else 0xF.
- dstE: icode 2,3,6 → D_rB; 8,9,A,B → RSP; else 0xF (cmov condition applied downstream).
- dstM: icode 5,B → D_rA; else 0xF.
- valA priority: icode 7 or 8 → D_valP; else srcA==e_dstE → e_valE; ==M_dstM → m_valM; ==M_dstE → M_valE; ==W_dstM → W_valM; ==W_dstE → W_valE; else regfile[srcA].
- valB: same chain without the valP term.
- No forwarding match when the source ID is 0xF; valA/valB = 0 for srcs of 0xF.
- Register file: on posedge write W_valE to W_dstE and W_valM to W_dstM when ≠0xF; if W_dstE==W_dstM, W_valM wins. Reads combinational; same-cycle write/read covered by W forwarding.
- E register on posedge: E_bubble=1 → icode=1, ifun=0, stat=AOK, valC/valA/valB=0, all four IDs=0xF; else capture computed values and D_stat/D_icode/D_ifun/D_valC.
- Status passes unchanged; decode raises no new status.

## Timing
- d_srcA/d_srcB and forwarding select: zero-cycle combinational from D and forwarding inputs.
- Decode → E register: 1 cycle.
- W write visible in regfile array next cycle, via forwarding same cycle.
- rst asserted (any time, async): all 15 registers = 0; E register = bubble state above. Held until rst deasserts; first capture on first posedge after deassertion.
- E_bubble and rst together: rst dominates.
- No E stall input; hazard unit stalls upstream by holding D.

## Structure
- Shared package y86_pkg: icode constants (HALT..POPQ), stat codes, RNONE, RSP, bubble defaults — also used by fetch/execute.
- Sub-module regfile (2 async read, 2 sync write ports, async reset, dstM-wins rule); decode instantiates it plus the forward mux and E register.

## Test plan
- Reset: assert rst mid-run → E_icode=1, E_dstE=E_dstM=0xF, E_stat=1; all regs 0 at next read.
- Write-back: W_dstE=3, W_valE=0x55 then D=OPq rA=3 rB=3 → E_valA=E_valB=0x55, E_dstE=3.
- Forward priority: srcA=2 with e_dstE=2 (0x11), M_dstE=2 (0x22), W_dstE=2 (0x33) → E_valA=0x11; remove e → 0x22; remove M → 0x33.
- popq hazard: M_dstM=4 m_valM=0x80 and M_dstE=4 M_valE=0x90, D=ret → E_valA=0x80 (M_dstM priority), E_srcA=4.
- Dual write: W_dstE=W_dstM=4, valE=0x10, valM=0x20 → reg4=0x20.
- call/jXX: D_icode=8, D_valP=0x40 → E_valA=0x40, E_valB=reg4, E_dstE=4; with E_bubble=1 → nop bubble instead.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: instruction codes, status codes,
// special register IDs and the E-stage bubble contents.
package y86_pkg;

   localparam int NREG = 15;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 4'd4;

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   localparam logic [3:0] BUBBLE_ICODE = I_NOP;
   localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
   localparam logic [2:0] BUBBLE_STAT  = STAT_AOK;

endpackage

// File: rtl/decode_regfile.sv
// Y86-64 program register file: 15 x 64 bits, two combinational read ports
// and two write ports from write-back.
module decode_regfile
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   input  logic [3:0]  dst_e,
   input  logic [63:0] wval_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] wval_m
);

   logic [63:0] regs [NREG];

   // The M port is written last so a load wins when both ports target one register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (dst_e != RNONE) regs[dst_e] <= wval_e;
         if (dst_m != RNONE) regs[dst_m] <= wval_m;
      end
   end

   assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
   assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode.sv
// Y86-64 decode/write-back stage: register ID selection, operand forwarding,
// register file ownership and the E pipeline register.
module decode
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  D_stat,
   input  logic [3:0]  D_icode,
   input  logic [3:0]  D_ifun,
   input  logic [3:0]  D_rA,
   input  logic [3:0]  D_rB,
   input  logic [63:0] D_valC,
   input  logic [63:0] D_valP,
   input  logic [3:0]  e_dstE,
   input  logic [63:0] e_valE,
   input  logic [3:0]  M_dstE,
   input  logic [63:0] M_valE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] m_valM,
   input  logic [3:0]  W_dstE,
   input  logic [63:0] W_valE,
   input  logic [3:0]  W_dstM,
   input  logic [63:0] W_valM,
   input  logic        E_bubble,
   output logic [3:0]  d_srcA,
   output logic [3:0]  d_srcB,
   output logic [2:0]  E_stat,
   output logic [3:0]  E_icode,
   output logic [3:0]  E_ifun,
   output logic [63:0] E_valC,
   output logic [63:0] E_valA,
   output logic [63:0] E_valB,
   output logic [3:0]  E_dstE,
   output logic [3:0]  E_dstM,
   output logic [3:0]  E_srcA,
   output logic [3:0]  E_srcB
);

   logic [3:0]  d_dstE, d_dstM;
   logic [63:0] rf_a, rf_b;
   logic [63:0] d_valA, d_valB;

   decode_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .src_a  (d_srcA),
      .src_b  (d_srcB),
      .val_a  (rf_a),
      .val_b  (rf_b),
      .dst_e  (W_dstE),
      .wval_e (W_valE),
      .dst_m  (W_dstM),
      .wval_m (W_valM)
   );

   always_comb begin
      d_srcA = RNONE;
      d_srcB = RNONE;
      d_dstE = RNONE;
      d_dstM = RNONE;
      case (D_icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
         I_RET, I_POPQ:                      d_srcA = RSP;
         default: ;
      endcase
      case (D_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:         d_srcB = D_rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_srcB = RSP;
         default: ;
      endcase
      case (D_icode)
         I_RRMOVQ, I_IRMOVQ, I_OPQ:         d_dstE = D_rB;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:    d_dstE = RSP;
         default: ;
      endcase
      case (D_icode)
         I_MRMOVQ, I_POPQ:                  d_dstM = D_rA;
         default: ;
      endcase
   end

   // Youngest producer wins; RNONE sources never match and read as zero
   always_comb begin
      d_valA = '0;
      if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
      else if (d_srcA != RNONE) begin
         if      (d_srcA == e_dstE) d_valA = e_valE;
         else if (d_srcA == M_dstM) d_valA = m_valM;
         else if (d_srcA == M_dstE) d_valA = M_valE;
         else if (d_srcA == W_dstM) d_valA = W_valM;
         else if (d_srcA == W_dstE) d_valA = W_valE;
         else                       d_valA = rf_a;
      end
   end

   always_comb begin
      d_valB = '0;
      if (d_srcB != RNONE) begin
         if      (d_srcB == e_dstE) d_valB = e_valE;
         else if (d_srcB == M_dstM) d_valB = m_valM;
         else if (d_srcB == M_dstE) d_valB = M_valE;
         else if (d_srcB == W_dstM) d_valB = W_valM;
         else if (d_srcB == W_dstE) d_valB = W_valE;
         else                       d_valB = rf_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || E_bubble) begin
         E_stat  <= BUBBLE_STAT;
         E_icode <= BUBBLE_ICODE;
         E_ifun  <= BUBBLE_IFUN;
         E_valC  <= '0;
         E_valA  <= '0;
         E_valB  <= '0;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
      end else begin
         E_stat  <= D_stat;
         E_icode <= D_icode;
         E_ifun  <= D_ifun;
         E_valC  <= D_valC;
         E_valA  <= d_valA;
         E_valB  <= d_valB;
         E_dstE  <= d_dstE;
         E_dstM  <= d_dstM;
         E_srcA  <= d_srcA;
         E_srcB  <= d_srcB;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage: ID selection, forwarding
// priority, register file writes, bubbles and asynchronous reset.
module tb_decode;
   import y86_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  D_stat;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
   logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
   logic        E_bubble;
   logic [3:0]  d_srcA, d_srcB;
   logic [2:0]  E_stat;
   logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
   logic [63:0] E_valC, E_valA, E_valB;

   int errors = 0;
   int checks = 0;

   decode dut (
      .clk(clk), .rst(rst),
      .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
      .D_valC(D_valC), .D_valP(D_valP),
      .e_dstE(e_dstE), .e_valE(e_valE),
      .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
      .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
      .E_bubble(E_bubble),
      .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Idle all forwarding sources and the write ports
   task automatic clearFwd();
      e_dstE = RNONE; M_dstE = RNONE; M_dstM = RNONE; W_dstE = RNONE; W_dstM = RNONE;
      e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
   endtask

   task automatic setD(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
      D_stat = STAT_AOK; D_icode = icode; D_ifun = 4'h0; D_rA = ra; D_rB = rb;
      D_valC = valc; D_valP = valp;
   endtask

   // Clock one edge, then settle so outputs are sampled away from the edge
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; E_bubble = 1'b0;
      clearFwd();
      setD(I_NOP, RNONE, RNONE, 64'h0, 64'h0);
      #3;
      checkOutput("rst_icode", E_icode, 64'(I_NOP));
      checkOutput("rst_stat",  E_stat,  64'(STAT_AOK));
      checkOutput("rst_dstE",  E_dstE,  64'hF);
      checkOutput("rst_dstM",  E_dstM,  64'hF);
      @(negedge clk); rst = 1'b0;

      // Write reg3 through W, then read it back through the register file
      W_dstE = 4'd3; W_valE = 64'h55;
      applyStimulus();
      clearFwd();
      setD(I_OPQ, 4'd3, 4'd3, 64'h0, 64'h0);
      #1;
      checkOutput("opq_d_srcA", d_srcA, 64'd3);
      checkOutput("opq_d_srcB", d_srcB, 64'd3);
      applyStimulus();
      checkOutput("wb_valA", E_valA, 64'h55);
      checkOutput("wb_valB", E_valB, 64'h55);
      checkOutput("wb_dstE", E_dstE, 64'd3);
      checkOutput("wb_dstM", E_dstM, 64'hF);
      checkOutput("wb_icode", E_icode, 64'(I_OPQ));

      // Forwarding priority e > M > W > regfile
      setD(I_RRMOVQ, 4'd2, 4'd5, 64'h0, 64'h0);
      e_dstE = 4'd2; e_valE = 64'h11;
      M_dstE = 4'd2; M_valE = 64'h22;
      W_dstE = 4'd2; W_valE = 64'h33;
      applyStimulus();
      checkOutput("fwd_e", E_valA, 64'h11);
      checkOutput("rr_valB", E_valB, 64'h0);
      checkOutput("rr_dstE", E_dstE, 64'd5);
      e_dstE = RNONE;
      applyStimulus();
      checkOutput("fwd_M", E_valA, 64'h22);
      M_dstE = RNONE;
      applyStimulus();
      checkOutput("fwd_W", E_valA, 64'h33);
      W_dstE = RNONE; W_valE = 64'h0;
      applyStimulus();
      checkOutput("fwd_rf", E_valA, 64'h33);

      // ret with a pending popq: M_dstM outranks M_dstE
      setD(I_RET, RNONE, RNONE, 64'h0, 64'h0);
      M_dstM = 4'd4; m_valM = 64'h80;
      M_dstE = 4'd4; M_valE = 64'h90;
      applyStimulus();
      checkOutput("ret_valA", E_valA, 64'h80);
      checkOutput("ret_valB", E_valB, 64'h80);
      checkOutput("ret_srcA", E_srcA, 64'd4);
      checkOutput("ret_dstE", E_dstE, 64'd4);
      clearFwd();

      // Both write ports to reg4: the M value must land
      setD(I_NOP, RNONE, RNONE, 64'h0, 64'h0);
      W_dstE = 4'd4; W_valE = 64'h10; W_dstM = 4'd4; W_valM = 64'h20;
      applyStimulus();
      clearFwd();
      setD(I_OPQ, 4'd4, 4'd4, 64'h0, 64'h0);
      applyStimulus();
      checkOutput("dual_valA", E_valA, 64'h20);
      checkOutput("dual_valB", E_valB, 64'h20);

      // call: valA is valP, valB is the stack pointer
      setD(I_CALL, RNONE, RNONE, 64'h1234, 64'h40);
      applyStimulus();
      checkOutput("call_valA", E_valA, 64'h40);
      checkOutput("call_valB", E_valB, 64'h20);
      checkOutput("call_dstE", E_dstE, 64'd4);
      checkOutput("call_srcA", E_srcA, 64'hF);
      checkOutput("call_valC", E_valC, 64'h1234);

      E_bubble = 1'b1;
      applyStimulus();
      checkOutput("bub_icode", E_icode, 64'(I_NOP));
      checkOutput("bub_valA", E_valA, 64'h0);
      checkOutput("bub_dstE", E_dstE, 64'hF);
      checkOutput("bub_valC", E_valC, 64'h0);
      E_bubble = 1'b0;

      setD(I_PUSHQ, 4'd3, RNONE, 64'h0, 64'h0);
      applyStimulus();
      checkOutput("push_valA", E_valA, 64'h55);
      checkOutput("push_valB", E_valB, 64'h20);
      checkOutput("push_dstE", E_dstE, 64'd4);

      setD(I_MRMOVQ, 4'd7, 4'd3, 64'h8, 64'h0);
      applyStimulus();
      checkOutput("mr_dstM", E_dstM, 64'd7);
      checkOutput("mr_dstE", E_dstE, 64'hF);
      checkOutput("mr_valB", E_valB, 64'h55);
      checkOutput("mr_valA", E_valA, 64'h0);

      setD(I_HALT, RNONE, RNONE, 64'h0, 64'h0);
      D_stat = STAT_ADR; D_ifun = 4'h3;
      applyStimulus();
      checkOutput("stat_pass", E_stat, 64'(STAT_ADR));
      checkOutput("halt_icode", E_icode, 64'(I_HALT));
      checkOutput("ifun_pass", E_ifun, 64'h3);

      // Asynchronous reset mid-cycle clears E and the register file
      setD(I_OPQ, 4'd4, 4'd3, 64'h0, 64'h0);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_icode", E_icode, 64'(I_NOP));
      checkOutput("arst_stat", E_stat, 64'(STAT_AOK));
      checkOutput("arst_dstE", E_dstE, 64'hF);
      E_bubble = 1'b0;
      @(negedge clk); rst = 1'b0;
      applyStimulus();
      checkOutput("arst_reg4", E_valA, 64'h0);
      checkOutput("arst_reg3", E_valB, 64'h0);
      checkOutput("arst_first_icode", E_icode, 64'(I_OPQ));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
